// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mult_share_arbiter
// Brief   : Round-robin arbiter/sequencer sharing one serial multiplier among
//           NREQ requesters. Optional WAIT timeout via MULT_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mult_share_arbiter #(
  parameter int W       = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*W-1:0]     a_in,
  input  logic [NREQ*W-1:0]     b_in,
  output logic [NREQ-1:0]       ack,
  output logic [2*W-1:0]        rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  mul_start,
  output logic [W-1:0]          mul_a,
  output logic [W-1:0]          mul_b,
  input  logic                  mul_done,
  input  logic [2*W-1:0]        mul_product
);

  localparam int              c_pw     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [c_pw:0]   c_nreq_w = (c_pw+1)'(NREQ);
  localparam logic [c_pw-1:0] c_last   = c_pw'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mult_share_arbiter: unsupported NREQ/TIMEOUT");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [c_pw-1:0] ptr_q;
  logic [c_pw-1:0] grant_q;

  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = a_in[gi*W +: W];
    assign b_arr[gi] = b_in[gi*W +: W];
  end

  // Rotate req so ptr sits at bit 0, pick the lowest set bit, rotate back.
  logic [2*NREQ-1:0] req_dbl_d;
  logic [NREQ-1:0]   req_rot_d;
  logic [c_pw-1:0]   off_d;
  logic [c_pw:0]     sum_d;
  logic [c_pw-1:0]   grant_d;

  always_comb begin
    req_dbl_d = {req, req} >> ptr_q;
    req_rot_d = req_dbl_d[NREQ-1:0];
    off_d     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot_d[i]) off_d = i[c_pw-1:0];
    end
    sum_d = {1'b0, ptr_q} + {1'b0, off_d};
    if (sum_d >= c_nreq_w) sum_d = sum_d - c_nreq_w;
    grant_d = sum_d[c_pw-1:0];
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int              c_cw       = $clog2(TIMEOUT + 1);
  localparam logic [c_cw-1:0] c_tmo_last = c_cw'(TIMEOUT - 1);
  logic [c_cw-1:0] tmo_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      ack       <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      tmo_q     <= '0;
`endif
    end else begin
      mul_start <= 1'b0;
      ack       <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant_q   <= grant_d;
            mul_a     <= a_arr[grant_d];
            mul_b     <= b_arr[grant_d];
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef MULT_ARB_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done coinciding with expiry takes priority over the timeout.
          if (mul_done) begin
            rsp_data     <= mul_product;
            ack[grant_q] <= 1'b1;
            state_q      <= ST_RESP;
`ifdef MULT_ARB_TIMEOUT_EN
            rsp_err      <= 1'b0;
          end else if (tmo_q == c_tmo_last) begin
            rsp_data     <= '0;
            rsp_err      <= 1'b1;
            ack[grant_q] <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            tmo_q        <= tmo_q + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          ptr_q   <= (grant_q == c_last) ? '0 : grant_q + 1'b1;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
